instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly downstream of the PC update logic. It takes the 64-bit PC produced each step, issues a read request to instruction memory over a req/ack handshake, and captures the 32-bit instruction. It presents the instruction to decode with a valid/ready handshake. Misaligned PCs and memory timeouts are reported as faulted fetches, with a NOP substituted for the instruction.

---
 rtl/riscv_fetch_pkg.sv | 14 +
 rtl/fetch_timeout_counter.sv | 31 +++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts REQ cycles without an ack; flags the cycle whose increment would reach TIMEOUT.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A zero TIMEOUT still needs a legal one-bit counter; it simply never moves.
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LAST_INT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC -> memory req/ack -> instruction presented to decode with valid/ready.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               fetch_en,
  output logic               fetch_busy,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fault_misaligned,
  output logic               fault_timeout
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  fetch_state_t state;
  logic         start;
  logic         aligned;
  logic         tmo_clr;
  logic         tmo_en;
  logic         tmo_expired;

  assign aligned = (pc_in[1:0] & INSTR_ALIGN_MASK) == 2'b00;

  // A new fetch is taken from IDLE, or from HOLD in the same cycle decode drains it.
  assign start = fetch_en && ((state == IDLE) || ((state == HOLD) && instr_ready));

  assign fetch_busy = (state == REQ) || ((state == HOLD) && !instr_ready);

  assign tmo_clr = start && aligned;
  assign tmo_en  = (state == REQ) && !mem_ack;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_req          <= 1'b0;
      mem_addr         <= '0;
      instr_out        <= NOP;
      instr_pc         <= '0;
      instr_valid      <= 1'b0;
      fault_misaligned <= 1'b0;
      fault_timeout    <= 1'b0;
    end else if (start) begin
      mem_addr      <= pc_in;
      instr_pc      <= pc_in;
      fault_timeout <= 1'b0;
      if (aligned) begin
        state            <= REQ;
        mem_req          <= 1'b1;
        instr_valid      <= 1'b0;
        fault_misaligned <= 1'b0;
      end else begin
        // Misaligned fetches never touch memory; they go straight to decode as a faulted NOP.
        state            <= HOLD;
        mem_req          <= 1'b0;
        instr_valid      <= 1'b1;
        instr_out        <= NOP;
        fault_misaligned <= 1'b1;
      end
    end else begin
      case (state)
        REQ: begin
          // Ack takes priority over an expiring counter in the same cycle.
          if (mem_ack) begin
            state            <= HOLD;
            mem_req          <= 1'b0;
            instr_valid      <= 1'b1;
            instr_out        <= mem_rdata;
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b0;
          end else if (tmo_expired) begin
            state            <= HOLD;
            mem_req          <= 1'b0;
            instr_valid      <= 1'b1;
            instr_out        <= NOP;
            fault_misaligned <= 1'b0;
            fault_timeout    <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard on the decode-side handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in;
  logic        fetch_en;
  logic        fetch_busy;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault_misaligned;
  logic        fault_timeout;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fm;
    logic        ft;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .TIMEOUT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_in            (pc_in),
    .fetch_en         (fetch_en),
    .fetch_busy       (fetch_busy),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .fault_misaligned (fault_misaligned),
    .fault_timeout    (fault_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [63:0] pc, input logic fm, input logic ft);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.fm    = fm;
    e.ft    = ft;
    q.push_back(e);
  endtask

  // Issue an aligned fetch and ack it in the first REQ cycle.
  task automatic fetch_ack(input logic [63:0] pc, input logic [31:0] data);
    pc_in    = pc;
    fetch_en = 1'b1;
    push(data, pc, 1'b0, 1'b0);
    step();
    fetch_en  = 1'b0;
    chk("req_raised", 64'(mem_req), 64'd1);
    chk("req_addr", mem_addr, pc);
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack = 1'b0;
    chk("valid_after_ack", 64'(instr_valid), 64'd1);
    chk("req_dropped", 64'(mem_req), 64'd0);
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  // Monitor: every completed decode handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_transfer_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_instr", 64'(instr_out), 64'(e.instr));
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_misaligned", 64'(fault_misaligned), 64'(e.fm));
        chk("sb_timeout", 64'(fault_timeout), 64'(e.ft));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_instr_out"}, 64'(instr_out), 64'(NOP));
    chk({tag, "_instr_pc"}, instr_pc, 64'd0);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_fm"}, 64'(fault_misaligned), 64'd0);
    chk({tag, "_ft"}, 64'(fault_timeout), 64'd0);
    chk({tag, "_busy"}, 64'(fetch_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset       = 1'b1;
    pc_in       = '0;
    fetch_en    = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    step();
    step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // Basic fetch
    fetch_ack(64'h0, 32'h0050_0093);
    consume();
    chk("basic_valid_cleared", 64'(instr_valid), 64'd0);

    // Misaligned PC
    pc_in    = 64'h6;
    fetch_en = 1'b1;
    push(NOP, 64'h6, 1'b1, 1'b0);
    step();
    fetch_en = 1'b0;
    chk("mis_no_req", 64'(mem_req), 64'd0);
    chk("mis_valid", 64'(instr_valid), 64'd1);
    step();
    chk("mis_no_req_hold", 64'(mem_req), 64'd0);
    consume();

    // Timeout without ack
    pc_in    = 64'h100;
    fetch_en = 1'b1;
    push(NOP, 64'h100, 1'b0, 1'b1);
    step();
    fetch_en = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      step();
    end
    chk("tmo_req_cycles", 64'(n), 64'd4);
    chk("tmo_valid", 64'(instr_valid), 64'd1);
    consume();

    // Ack arriving in the last allowed REQ cycle wins over timeout
    pc_in    = 64'h104;
    fetch_en = 1'b1;
    push(32'h1111_1111, 64'h104, 1'b0, 1'b0);
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_req", 64'(mem_req), 64'd1);
      step();
    end
    chk("late_ack_req4", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    chk("late_ack_valid", 64'(instr_valid), 64'd1);
    chk("late_ack_req_off", 64'(mem_req), 64'd0);
    consume();

    // Backpressure with stray fetch_en and mem_ack
    fetch_ack(64'h200, 32'h2222_2222);
    fetch_en  = 1'b1;
    pc_in     = 64'h300;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_busy", 64'(fetch_busy), 64'd1);
      step();
      chk("bp_no_req", 64'(mem_req), 64'd0);
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_instr", 64'(instr_out), 64'h2222_2222);
      chk("bp_pc", instr_pc, 64'h200);
    end
    fetch_en = 1'b0;
    mem_ack  = 1'b0;
    consume();

    // Back-to-back: aligned follow-on, then a misaligned follow-on
    fetch_ack(64'h400, 32'h3333_3333);
    instr_ready = 1'b1;
    fetch_en    = 1'b1;
    pc_in       = 64'h8;
    step();
    instr_ready = 1'b0;
    fetch_en    = 1'b0;
    chk("b2b_req", 64'(mem_req), 64'd1);
    chk("b2b_addr", mem_addr, 64'h8);
    chk("b2b_valid_drop", 64'(instr_valid), 64'd0);
    push(32'h4444_4444, 64'h8, 1'b0, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h4444_4444;
    step();
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    fetch_en    = 1'b1;
    pc_in       = 64'hA;
    push(NOP, 64'hA, 1'b1, 1'b0);
    step();
    fetch_en = 1'b0;
    chk("b2b_mis_valid", 64'(instr_valid), 64'd1);
    chk("b2b_mis_no_req", 64'(mem_req), 64'd0);
    step();
    instr_ready = 1'b0;
    chk("b2b_mis_drained", 64'(instr_valid), 64'd0);

    // Reset during REQ, followed by a stale ack
    pc_in    = 64'h500;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("rst_mid_req_before", 64'(mem_req), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("rst_mid");
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    step();
    mem_ack = 1'b0;
    chk("stale_ack_valid", 64'(instr_valid), 64'd0);
    chk("stale_ack_req", 64'(mem_req), 64'd0);
    chk("stale_ack_instr", 64'(instr_out), 64'(NOP));

    step();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
